// File: rtl/svm_batch_sched_pkg.sv
// svm_batch_sched_pkg: shared constants, defaults and scheduler state encoding
package svm_batch_sched_pkg;
   localparam int Features = 13;
   localparam int Vectors = 25;
   localparam int MaxBatchDef = 16;
   localparam int TestWDef = 8;
   localparam int TimeoutDef = 1024;
   typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, STORE, DONE} sched_state_e;
   function automatic int cnt_w(input int max_batch);
      return $clog2(max_batch + 1);
   endfunction
endpackage

// File: rtl/svm_batch_sched_if.sv
// svm_batch_sched_if: job request, hw_svm core and result handshakes
interface svm_batch_sched_if import svm_batch_sched_pkg::*; #(
   parameter int MaxBatch = MaxBatchDef,
   parameter int TestW = TestWDef
);
   localparam int CntW = cnt_w(MaxBatch);
   logic req_valid;
   logic req_ready;
   logic [TestW-1:0] req_base;
   logic [CntW-1:0] req_count;
   logic core_start;
   logic [TestW-1:0] core_test_sel;
   logic core_label;
   logic core_label_valid;
   logic done_valid;
   logic done_ready;
   logic [MaxBatch-1:0] done_labels;
   logic [CntW-1:0] done_pos_count;
   logic done_error;
   modport slave(
      input req_valid, req_base, req_count, core_label, core_label_valid, done_ready,
      output req_ready, core_start, core_test_sel, done_valid, done_labels, done_pos_count, done_error
   );
   modport master(
      output req_valid, req_base, req_count, core_label, core_label_valid, done_ready,
      input req_ready, core_start, core_test_sel, done_valid, done_labels, done_pos_count, done_error
   );
endinterface

// File: rtl/svm_batch_sched_watchdog.sv
// svm_batch_sched_watchdog: per-vector down-counter; expires on the cycle it steps to zero,
// so a WAIT started after LAUNCH at cycle S ends in DONE at S+Timeout
module svm_batch_sched_watchdog #(
   parameter int Timeout = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic expired
);
   localparam int W = Timeout > 2 ? $clog2(Timeout) : 1;
   logic [W-1:0] cnt;
   always_ff @(posedge clk) begin
      if (!rst) cnt <= '0;
      else if (load) cnt <= W'(Timeout - 1);
      else if (en && cnt != '0) cnt <= cnt - W'(1);
   end
   assign expired = en && cnt == W'(1);
endmodule

// File: rtl/svm_batch_sched.sv
// svm_batch_sched: launches one hw_svm classification per vector of a job, packs the labels
// and returns them with a positive count; a per-vector watchdog aborts a silent core
module svm_batch_sched import svm_batch_sched_pkg::*; #(
   parameter int MaxBatch = MaxBatchDef,
   parameter int TestW = TestWDef,
   parameter int Timeout = TimeoutDef
) (
   input logic clk,
   input logic rst,
   svm_batch_sched_if.slave bus
);
   localparam int CntW = cnt_w(MaxBatch);
   sched_state_e state, nxt;
   logic [TestW-1:0] base;
   logic [CntW-1:0] cnt, idx, pos;
   logic [MaxBatch-1:0] labels;
   logic err, lab, expired;
   svm_batch_sched_watchdog #(.Timeout(Timeout)) u_wd (
      .clk(clk),
      .rst(rst),
      .load(state == LAUNCH),
      .en(state == WAIT),
      .expired(expired)
   );
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         base <= '0;
         cnt <= '0;
         idx <= '0;
         pos <= '0;
         labels <= '0;
         err <= 1'b0;
         lab <= 1'b0;
      end else begin
         state <= nxt;
         if (state == IDLE && bus.req_valid) begin
            base <= bus.req_base;
            cnt <= bus.req_count > CntW'(MaxBatch) ? CntW'(MaxBatch) : bus.req_count;
            err <= bus.req_count > CntW'(MaxBatch);
            idx <= '0;
            pos <= '0;
            labels <= '0;
         end
         if (state == WAIT && bus.core_label_valid) lab <= bus.core_label;
         // a label in the expiry cycle wins over the abort
         if (state == WAIT && !bus.core_label_valid && expired) err <= 1'b1;
         if (state == STORE) begin
            labels <= labels | (MaxBatch'(lab) << idx);
            pos <= pos + CntW'(lab);
            idx <= idx + CntW'(1);
         end
      end
   end
   always_comb begin
      nxt = state;
      unique case (state)
         IDLE: nxt = bus.req_valid ? (bus.req_count == '0 ? DONE : LAUNCH) : IDLE;
         LAUNCH: nxt = WAIT;
         WAIT: nxt = bus.core_label_valid ? STORE : expired ? DONE : WAIT;
         STORE: nxt = idx + CntW'(1) == cnt ? DONE : LAUNCH;
         DONE: nxt = bus.done_ready ? IDLE : DONE;
         default: nxt = IDLE;
      endcase
      bus.req_ready = state == IDLE;
      bus.core_start = state == LAUNCH;
      bus.core_test_sel = base + TestW'(idx);
      bus.done_valid = state == DONE;
      bus.done_labels = bus.done_valid ? labels : '0;
      bus.done_pos_count = bus.done_valid ? pos : '0;
      bus.done_error = bus.done_valid && err;
   end
endmodule

// File: tb/tb_svm_batch_sched.sv
// tb_svm_batch_sched: directed jobs against a timeline model of the scheduler, with a
// programmable-latency core responder (330 cycles unless a vector is made late or silent)
module tb_svm_batch_sched;
   localparam int MaxBatch = 16;
   localparam int TestW = 8;
   localparam int Timeout = 1024;
   localparam int Lat = 330;
   localparam int CntW = $clog2(MaxBatch + 1);
   logic clk = 1'b0;
   logic rst = 1'b0;
   int cyc = 0;
   svm_batch_sched_if #(.MaxBatch(MaxBatch), .TestW(TestW)) bus ();
   svm_batch_sched #(.MaxBatch(MaxBatch), .TestW(TestW), .Timeout(Timeout)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   int dly_tab[32];
   bit lab_tab[32];
   int job_id = 0;
   int spur_cnt = 0;
   bit active = 1'b0;
   int t0 = 0;
   int m_labels, m_pos, m_err, m_starts, m_done_rel;
   int m_start_rel[MaxBatch];
   int m_sel[MaxBatch];
   string dir_name[256];
   int dir_act[256];
   int dir_exp[256];
   int dir_wr = 0;
   int dir_rd = 0;
   int n_tests = 0;
   int n_fail = 0;
   int n_start = 0;
   int cjob = 0;
   bit seen_done = 1'b0;
   int rem = 0;
   int rvec = 0;
   int rjob = 0;
   int spur_seen = 0;
   // core responder: label arrives dly cycles after the start cycle, dly 0 means silent
   always @(negedge clk) begin
      logic lv;
      if (rjob != job_id) begin
         rjob = job_id;
         rvec = 0;
      end
      lv = 1'b0;
      if (rem > 0) begin
         rem--;
         if (rem == 0) begin
            lv = 1'b1;
            bus.core_label = lab_tab[rvec - 1];
         end
      end
      if (spur_seen != spur_cnt) begin
         spur_seen = spur_cnt;
         lv = 1'b1;
         bus.core_label = 1'b1;
      end
      if (!rst) rem = 0;
      else if (bus.core_start) begin
         rem = dly_tab[rvec];
         rvec++;
      end
      bus.core_label_valid = lv;
   end
   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask
   // the single checker: directed expectations from the driver plus per-cycle model compare
   always @(negedge clk) begin
      while (dir_rd != dir_wr) begin
         chk(dir_name[dir_rd], dir_act[dir_rd], dir_exp[dir_rd]);
         dir_rd++;
      end
      if (cjob != job_id) begin
         cjob = job_id;
         n_start = 0;
         seen_done = 1'b0;
      end
      if (active && bus.core_start) begin
         if (n_start >= m_starts) begin
            n_tests++;
            n_fail++;
            $display("FAIL extra core_start: got start %0d, expected only %0d", n_start + 1, m_starts);
         end else begin
            chk("core_start cycle", cyc - t0, m_start_rel[n_start]);
            chk("core_test_sel", int'(bus.core_test_sel), m_sel[n_start]);
         end
         n_start++;
      end
      if (active && bus.done_valid) begin
         if (!seen_done) begin
            chk("done cycle", cyc - t0, m_done_rel);
            seen_done = 1'b1;
         end
         chk("done_labels", int'(bus.done_labels), m_labels);
         chk("done_pos_count", int'(bus.done_pos_count), m_pos);
         chk("done_error", int'(bus.done_error), m_err);
      end
   end
   task automatic put(input string name, input int act, input int exp);
      dir_name[dir_wr] = name;
      dir_act[dir_wr] = act;
      dir_exp[dir_wr] = exp;
      dir_wr++;
   endtask
   task automatic set_tabs(input int d);
      for (int i = 0; i < 32; i++) begin
         dly_tab[i] = d;
         lab_tab[i] = 1'b0;
      end
   endtask
   // timeline model: start i at 1 + sum(d+2), done two cycles after the last label,
   // or Timeout cycles after the start of a silent vector
   task automatic model(input int base, input int count);
      int n, t;
      n = count > MaxBatch ? MaxBatch : count;
      m_err = count > MaxBatch ? 1 : 0;
      m_labels = 0;
      m_pos = 0;
      m_starts = 0;
      m_done_rel = 1;
      t = 1;
      for (int i = 0; i < n; i++) begin
         m_start_rel[i] = t;
         m_sel[i] = (base + i) % (1 << TestW);
         m_starts++;
         if (dly_tab[i] == 0 || dly_tab[i] >= Timeout) begin
            m_err = 1;
            m_done_rel = t + Timeout;
            break;
         end
         if (lab_tab[i]) begin
            m_labels += 1 << i;
            m_pos++;
         end
         t += dly_tab[i] + 2;
         m_done_rel = t;
      end
   endtask
   task automatic request(input int base, input int count);
      @(posedge clk);
      #1;
      bus.req_base = TestW'(base);
      bus.req_count = CntW'(count);
      bus.req_valid = 1'b1;
      t0 = cyc;
      job_id++;
      active = 1'b1;
      @(negedge clk);
      put("req_ready at request", int'(bus.req_ready), 1);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
   endtask
   task automatic run_job(input string tag, input int base, input int count, input int hold,
                          input int l_lab, input int l_pos, input int l_err, input int l_done);
      int k, bad;
      model(base, count);
      put({tag, " model labels"}, m_labels, l_lab);
      put({tag, " model pos"}, m_pos, l_pos);
      put({tag, " model err"}, m_err, l_err);
      put({tag, " model done cycle"}, m_done_rel, l_done);
      request(base, count);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!bus.done_valid && k < 20000);
      put({tag, " done_valid within bound"}, int'(bus.done_valid), 1);
      put({tag, " done cycle literal"}, cyc - t0, l_done);
      put({tag, " labels literal"}, int'(bus.done_labels), l_lab);
      put({tag, " pos literal"}, int'(bus.done_pos_count), l_pos);
      put({tag, " err literal"}, int'(bus.done_error), l_err);
      bad = 0;
      for (int i = 0; i < hold; i++) begin
         if (i == hold / 2) spur_cnt++;
         @(negedge clk);
         if (bus.req_ready || !bus.done_valid) bad++;
      end
      if (hold > 0) put({tag, " done held, req_ready low"}, bad, 0);
      @(posedge clk);
      #1 bus.done_ready = 1'b1;
      @(posedge clk);
      #1 bus.done_ready = 1'b0;
      @(negedge clk);
      put({tag, " req_ready after accept"}, int'(bus.req_ready), 1);
      put({tag, " done_valid after accept"}, int'(bus.done_valid), 0);
      active = 1'b0;
      put({tag, " core_start count"}, n_start, m_starts);
   endtask
   initial begin
      #500000;
      $display("FAIL global time limit: simulation still running at cycle %0d, expected finish", cyc);
      $fatal(1, "global time limit");
   end
   initial begin
      int k, bad;
      bus.req_valid = 1'b0;
      bus.req_base = '0;
      bus.req_count = '0;
      bus.done_ready = 1'b0;
      set_tabs(Lat);
      repeat (3) @(posedge clk);
      @(negedge clk);
      put("reset req_ready", int'(bus.req_ready), 1);
      put("reset core_start", int'(bus.core_start), 0);
      put("reset core_test_sel", int'(bus.core_test_sel), 0);
      put("reset done_valid", int'(bus.done_valid), 0);
      put("reset done_labels", int'(bus.done_labels), 0);
      put("reset done_pos_count", int'(bus.done_pos_count), 0);
      put("reset done_error", int'(bus.done_error), 0);
      @(posedge clk);
      #1 rst = 1'b1;
      set_tabs(Lat);
      lab_tab[0] = 1'b1;
      lab_tab[2] = 1'b1;
      lab_tab[3] = 1'b1;
      run_job("basic", 3, 4, 0, 13, 3, 0, 1 + 4 * (Lat + 2));
      set_tabs(Lat);
      run_job("empty", 7, 0, 0, 0, 0, 0, 1);
      set_tabs(Lat);
      for (int i = 0; i < 32; i++) lab_tab[i] = (i % 3) == 0;
      run_job("clamp", 100, 20, 0, 16'h9249, 6, 1, 1 + 16 * (Lat + 2));
      set_tabs(Lat);
      for (int i = 0; i < 4; i++) lab_tab[i] = 1'b1;
      dly_tab[2] = 0;
      run_job("watchdog", 10, 4, 0, 3, 2, 1, 1 + 2 * (Lat + 2) + Timeout);
      set_tabs(Lat);
      dly_tab[0] = Timeout - 1;
      lab_tab[0] = 1'b1;
      run_job("label at expiry", 0, 1, 0, 1, 1, 0, 1 + Timeout + 1);
      set_tabs(Lat);
      lab_tab[1] = 1'b1;
      run_job("hold", 40, 2, 50, 2, 1, 0, 1 + 2 * (Lat + 2));
      spur_cnt++;
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (!bus.req_ready || bus.core_start || bus.done_valid) bad++;
      end
      put("spurious label in idle", bad, 0);
      set_tabs(Lat);
      model(20, 4);
      request(20, 4);
      k = 0;
      while (n_start < 2 && k < 2000) begin
         @(negedge clk);
         k++;
      end
      put("rst: vector 1 started", n_start, 2);
      repeat (10) @(negedge clk);
      active = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      put("rst: req_ready", int'(bus.req_ready), 1);
      put("rst: done_valid", int'(bus.done_valid), 0);
      put("rst: core_start", int'(bus.core_start), 0);
      bad = 0;
      repeat (400) begin
         @(negedge clk);
         if (bus.done_valid || bus.core_start || !bus.req_ready) bad++;
      end
      put("rst: job dropped", bad, 0);
      set_tabs(Lat);
      lab_tab[1] = 1'b1;
      lab_tab[2] = 1'b1;
      run_job("wrap after reset", 254, 3, 0, 6, 2, 0, 1 + 3 * (Lat + 2));
      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
